// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR filter family.
// State encoding, accumulator sizing and output saturation.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH
    } fir_state_t;

    function automatic int acc_width(int data_w, int coef_w, int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    function automatic logic signed [63:0] saturate(
        logic signed [63:0] value,
        int                 out_w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/fir_sat_shift.sv
// Arithmetic right shift of the accumulator, then clamp
// into the signed output range.
module fir_sat_shift
    import fir_pkg::*;
#(
    parameter int ACC_W = 11,
    parameter int SHIFT = 0,
    parameter int OUT_W = 8
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] y
);

    logic signed [ACC_W-1:0] shifted;

    // Floor-rounding shift keeps the sign of negative sums.
    assign shifted = acc >>> SHIFT;
    assign y = OUT_W'(saturate(64'(shifted), OUT_W));

endmodule

// File: rtl/fir_param_core.sv
// Parametrised streaming FIR: delay line, coefficient bank,
// load FSM, product stage and registered saturated sum.
module fir_param_core
    import fir_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int COEF_W = 2,
    parameter int TAPS   = 8,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [COEF_W-1:0] coef_in,
    input  logic                     coef_valid,
    output logic                     coef_ready,
    output logic                     coef_done,
    output logic signed [OUT_W-1:0]  y_out,
    output logic                     y_valid
);

    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    localparam int CNT_W = $clog2(TAPS);

    logic [1:0]  rst_sync;
    logic        rst_n;
    logic        active;
    fir_state_t  state;
    fir_state_t  state_nx;
    logic [CNT_W-1:0] cnt;
    logic        last;
    logic        in_acc;
    logic        coef_acc;
    logic        v0;
    logic        v1;

    logic signed [COEF_W-1:0] coef [TAPS];
    logic signed [DATA_W-1:0] dly  [TAPS];
    logic signed [ACC_W-1:0]  prod [TAPS];
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [OUT_W-1:0]  y_sat;

    // Reset asserts at once and releases two edges later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
            active   <= 1'b0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
            active   <= rst_sync[0];
        end
    end

    assign rst_n    = rst_sync[1];
    assign in_acc   = in_valid && in_ready;
    assign coef_acc = coef_valid && coef_ready;
    assign last     = (cnt == CNT_W'(TAPS - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // FSM next-state: a word starts a load, the last word flushes.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (coef_acc) state_nx = LOAD;
            LOAD:    if (coef_acc && last) state_nx = FLUSH;
            FLUSH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: coefficients win over samples in IDLE.
    always_comb begin
        in_ready   = 1'b0;
        coef_ready = 1'b0;
        coef_done  = 1'b0;
        if (active) begin
            unique case (state)
                IDLE: begin
                    in_ready   = !coef_valid;
                    coef_ready = 1'b1;
                end
                LOAD:    coef_ready = 1'b1;
                FLUSH:   coef_done  = 1'b1;
                default: ;
            endcase
        end
    end

    // Coefficient bank written in tap order; reset gives pass-through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int k = 0; k < TAPS; k++)
                coef[k] <= (k == 0) ? COEF_W'(1) : COEF_W'(0);
        end else if (state == FLUSH) begin
            cnt <= '0;
        end else if (coef_acc) begin
            cnt <= cnt + 1'b1;
            for (int k = 0; k < TAPS; k++)
                if (cnt == CNT_W'(k)) coef[k] <= coef_in;
        end
    end

    // Delay line shifts per accepted sample, cleared after a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) dly[k] <= '0;
        end else if (state == FLUSH) begin
            for (int k = 0; k < TAPS; k++) dly[k] <= '0;
        end else if (in_acc) begin
            dly[0] <= x_in;
            for (int k = 1; k < TAPS; k++) dly[k] <= dly[k-1];
        end
    end

    // Product stage sees the shifted line one cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            for (int k = 0; k < TAPS; k++) prod[k] <= '0;
        end else begin
            v0 <= in_acc;
            v1 <= v0;
            if (v0) begin
                for (int k = 0; k < TAPS; k++)
                    prod[k] <= ACC_W'(coef[k]) * ACC_W'(dly[k]);
            end
        end
    end

    // Full-precision sum of all products.
    always_comb begin
        acc_sum = '0;
        for (int k = 0; k < TAPS; k++) acc_sum = acc_sum + prod[k];
    end

    fir_sat_shift #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_sat (
        .acc (acc_sum),
        .y   (y_sat)
    );

    // Output register holds the last result; valid is a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_out   <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= v1;
            if (v1) y_out <= y_sat;
        end
    end

endmodule

// File: tb/tb_fir_param_core.sv
// Directed bench for fir_param_core: default instance plus a
// SHIFT=2 instance, checked with immediate assertions.
module tb_fir_param_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic signed [5:0] x_in;
    logic              in_valid;
    logic              in_ready;
    logic signed [1:0] coef_in;
    logic              coef_valid;
    logic              coef_ready;
    logic              coef_done;
    logic signed [7:0] y_out;
    logic              y_valid;

    logic signed [5:0] x_in_b;
    logic              in_valid_b;
    logic              in_ready_b;
    logic signed [1:0] coef_in_b;
    logic              coef_valid_b;
    logic              coef_ready_b;
    logic              coef_done_b;
    logic signed [7:0] y_out_b;
    logic              y_valid_b;

    fir_param_core dut (
        .clk        (clk),
        .reset      (reset),
        .x_in       (x_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .coef_in    (coef_in),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_done  (coef_done),
        .y_out      (y_out),
        .y_valid    (y_valid)
    );

    fir_param_core #(.SHIFT(2)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .x_in       (x_in_b),
        .in_valid   (in_valid_b),
        .in_ready   (in_ready_b),
        .coef_in    (coef_in_b),
        .coef_valid (coef_valid_b),
        .coef_ready (coef_ready_b),
        .coef_done  (coef_done_b),
        .y_out      (y_out_b),
        .y_valid    (y_valid_b)
    );

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int word_cnt = 0;
    int samp_cnt = 0;
    int d0;
    int w0;
    int s0;
    logic signed [7:0] got[$];
    int sx[$];
    int ex[$];
    int cw[$];

    always @(posedge clk) begin
        if (coef_done) done_cnt <= done_cnt + 1;
        if (coef_valid && coef_ready) word_cnt <= word_cnt + 1;
        if (in_valid && in_ready) samp_cnt <= samp_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_stream(input string tag);
        chk({tag, " count"}, got.size(), ex.size());
        for (int i = 0; i < ex.size(); i++)
            if (i < got.size())
                chk($sformatf("%s[%0d]", tag, i), got[i], ex[i]);
    endtask

    task automatic run_a();
        got.delete();
        for (int i = 0; i < sx.size() + 4; i++) begin
            if (i < sx.size()) begin
                x_in = 6'(sx[i]);
                in_valid = 1'b1;
            end else begin
                x_in = '0;
                in_valid = 1'b0;
            end
            step();
            if (y_valid) got.push_back(y_out);
        end
    endtask

    task automatic run_b();
        got.delete();
        for (int i = 0; i < sx.size() + 4; i++) begin
            if (i < sx.size()) begin
                x_in_b = 6'(sx[i]);
                in_valid_b = 1'b1;
            end else begin
                x_in_b = '0;
                in_valid_b = 1'b0;
            end
            step();
            if (y_valid_b) got.push_back(y_out_b);
        end
    endtask

    task automatic load(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            coef_in = 2'(cw[i]);
            coef_valid = 1'b1;
            step();
            coef_valid = 1'b0;
            if (i < n - 1) repeat (gap) step();
        end
        if (n == 8) begin
            chk("load coef_done in flush", coef_done, 1);
            chk("load coef_ready in flush", coef_ready, 0);
            step();
            chk("load coef_done after flush", coef_done, 0);
        end
    endtask

    initial begin
        reset = 1'b0;
        x_in = '0; in_valid = 1'b0;
        coef_in = '0; coef_valid = 1'b0;
        x_in_b = '0; in_valid_b = 1'b0;
        coef_in_b = '0; coef_valid_b = 1'b0;

        // reset state
        #3;
        chk("rst y_out", y_out, 0);
        chk("rst y_valid", y_valid, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst coef_ready", coef_ready, 0);
        chk("rst coef_done", coef_done, 0);
        chk("rst b y_out", y_out_b, 0);
        step();
        step();
        chk("rst held y_out", y_out, 0);
        chk("rst held in_ready", in_ready, 0);
        reset = 1'b1;
        repeat (3) step();
        chk("post-rst in_ready", in_ready, 1);
        chk("post-rst coef_ready", coef_ready, 1);

        // 1: pass-through latency, sample 5 then zeros
        x_in = 6'sd5; in_valid = 1'b1;
        step();
        chk("t1 lat0 y_valid", y_valid, 0);
        x_in = '0;
        step();
        chk("t1 lat1 y_valid", y_valid, 0);
        step();
        in_valid = 1'b0;
        chk("t1 lat2 y_valid", y_valid, 1);
        chk("t1 y0", y_out, 5);
        step();
        chk("t1 y1 valid", y_valid, 1);
        chk("t1 y1", y_out, 0);
        step();
        chk("t1 y2", y_out, 0);
        step();
        chk("t1 idle y_valid", y_valid, 0);

        // 2: alternating coefficients, impulse 3
        cw = '{1, 0, 1, 0, 1, 0, 1, 0};
        d0 = done_cnt;
        load(8, 0);
        chk("t2 coef_done pulses", done_cnt - d0, 1);
        sx = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ex = '{3, 0, 3, 0, 3, 0, 3, 0, 0, 0};
        run_a();
        check_stream("t2 impulse");

        // 3a: positive saturation
        cw = '{1, 1, 1, 1, 1, 1, 1, 1};
        load(8, 0);
        sx = '{31, 31, 31, 31, 31, 31, 31, 31};
        ex = '{31, 62, 93, 124, 127, 127, 127, 127};
        run_a();
        check_stream("t3 pos sat");

        // 3b: negative saturation
        cw = '{-2, -2, -2, -2, -2, -2, -2, -2};
        load(8, 0);
        ex = '{-62, -124, -128, -128, -128, -128, -128, -128};
        run_a();
        check_stream("t3 neg sat");

        // 4: gapped load with in_valid held high
        cw = '{1, -1, 0, 0, 0, 0, 0, 0};
        w0 = word_cnt;
        s0 = samp_cnt;
        x_in = 6'sd9;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            coef_in = 2'(cw[i]);
            coef_valid = 1'b1;
            #1;
            chk("t4 in_ready offer", in_ready, 0);
            step();
            coef_valid = 1'b0;
            #1;
            chk("t4 in_ready hold", in_ready, 0);
            if (i < 7 && (i % 2) == 0) begin
                step();
                chk("t4 in_ready gap", in_ready, 0);
            end
        end
        chk("t4 flush coef_done", coef_done, 1);
        chk("t4 flush coef_ready", coef_ready, 0);
        in_valid = 1'b0;
        step();
        chk("t4 words accepted", word_cnt - w0, 8);
        chk("t4 samples accepted", samp_cnt - s0, 0);
        sx = '{4, 6, 0, 0};
        ex = '{4, 2, -6, 0};
        run_a();
        check_stream("t4 fresh line");

        // 5: in-flight result survives load start, then reset mid-load
        x_in = 6'sd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        coef_in = '0; coef_valid = 1'b1;
        step();
        chk("t5 flight y_valid early", y_valid, 0);
        step();
        chk("t5 flight y_valid", y_valid, 1);
        chk("t5 flight old coefs", y_out, 5);
        step();
        step();
        coef_valid = 1'b0;
        chk("t5 mid-load coef_ready", coef_ready, 1);
        chk("t5 mid-load in_ready", in_ready, 0);
        d0 = done_cnt;
        #2 reset = 1'b0;
        #1;
        chk("t5 rst y_out", y_out, 0);
        chk("t5 rst coef_ready", coef_ready, 0);
        chk("t5 rst coef_done", coef_done, 0);
        step();
        step();
        reset = 1'b1;
        repeat (3) step();
        chk("t5 idle in_ready", in_ready, 1);
        chk("t5 no coef_done", done_cnt - d0, 0);
        sx = '{7, 0, 0};
        ex = '{7, 0, 0};
        run_a();
        check_stream("t5 pass-through");

        // 5b: pending result dropped by reset
        x_in = 6'sd9; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("t5b rst y_valid", y_valid, 0);
        step();
        chk("t5b held y_valid", y_valid, 0);
        chk("t5b held y_out", y_out, 0);
        reset = 1'b1;
        step();
        chk("t5b release y_valid", y_valid, 0);
        step();
        step();
        chk("t5b late y_valid", y_valid, 0);

        // 6: SHIFT=2 instance, floor rounding
        sx = '{-5, 31, -32, 0};
        ex = '{-2, 7, -8, 0};
        run_b();
        check_stream("t6 shift2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
